// File: rtl/add_serial_n.sv
// -----------------------------------------------------------------------------
// add_serial_n
// -----------------------------------------------------------------------------
// Purpose:
//   Bit-serial (n+1)-bit adder. Both operands are zero- or sign-extended to
//   n+1 bits and added LSB-first, one bit per clock, through a single full
//   adder and a carry flop. The result format matches the team's serial
//   subtractor: an n-bit sum plus an over flag holding bit n of the extended
//   sum. A start/busy/done handshake talks to the ALU sequencer.
//
// Parameters:
//   n     operand/result width in bits (n >= 2)
//   sign  0: operands zero-extended (unsigned)
//         1: operands sign-extended (two's complement)
//
// Ports:
//   clk_i    in   1  clock, rising edge active
//   rst_i    in   1  asynchronous, active-high reset
//   start_i  in   1  request; only looked at in IDLE or DONE
//   data0_i  in   n  operand A, captured on the accepting edge only
//   data1_i  in   n  operand B, captured on the accepting edge only
//   busy_o   out  1  high while the adder is shifting (n+1 cycles)
//   done_o   out  1  one-cycle pulse, result valid from this cycle on
//   data_o   out  n  sum[n-1:0], held until the next completion
//   over_o   out  1  sum[n], held until the next completion
//
// Timing (accepting edge = E0):
//   E1 .. E(n+1)  one sum bit per edge, LSB first
//   E(n+1)        data_o/over_o loaded, done_o rises, busy_o falls
//   Holding start_i high gives one result every n+2 cycles.
// -----------------------------------------------------------------------------
module add_serial_n #(
    parameter int n    = 8,
    parameter bit sign = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [n-1:0] data0_i,
    input  logic [n-1:0] data1_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [n-1:0] data_o,
    output logic         over_o
);

    // Bit counter wide enough to hold the value n (last shift index).
    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(n);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Full adder: returns {carry_out, sum}.
    // -------------------------------------------------------------------------
    function automatic logic [1:0] full_add(
        input logic a,
        input logic b,
        input logic c
    );
        logic s_v;
        logic c_v;
        s_v = a ^ b ^ c;
        c_v = (a & b) | (a & c) | (b & c);
        return {c_v, s_v};
    endfunction

    // -------------------------------------------------------------------------
    // Operand extension to n+1 bits.
    // -------------------------------------------------------------------------
    function automatic logic [n:0] extend(input logic [n-1:0] d);
        logic top_v;
        top_v = sign ? d[n-1] : 1'b0;
        return {top_v, d};
    endfunction

    // State and datapath registers.
    state_t         r_state;
    logic [n:0]     r_a;
    logic [n:0]     r_b;
    logic           r_carry;
    logic [CW-1:0]  r_cnt;
    // Holds sum bits 0..n-1 once n shifts have happened. Bit n (the final
    // sum bit) is never stored here; it goes straight into over_o on the
    // completing edge, while r_res still holds bits 0..n-1 unshifted.
    logic [n-1:0]   r_res;
    logic           r_busy;
    logic           r_done;
    logic [n-1:0]   r_data;
    logic           r_over;

    // Combinational control and datapath signals.
    state_t         w_state_nxt;
    logic           w_accept;
    logic           w_step;
    logic           w_finish;
    logic           w_last;
    logic [1:0]     w_fa;
    logic           w_sum_bit;
    logic           w_carry_nxt;
    logic [n:0]     w_ext_a;
    logic [n:0]     w_ext_b;

    // Extension, full adder and end-of-operation detect.
    always_comb begin
        w_ext_a     = extend(data0_i);
        w_ext_b     = extend(data1_i);
        w_fa        = full_add(r_a[0], r_b[0], r_carry);
        w_sum_bit   = w_fa[0];
        w_carry_nxt = w_fa[1];
        w_last      = (r_cnt == CNT_LAST);
    end

    // Next-state decode and per-edge datapath controls.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_SHIFT;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // start_i is deliberately not looked at here.
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                    w_finish    = 1'b1;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    w_state_nxt = ST_SHIFT;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake flags registered from the next state so they line up with it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_SHIFT);
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    // Operand shift registers, carry flop, bit counter and partial result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= CNT_ZERO;
            r_res   <= '0;
        end else if (w_accept) begin
            r_a     <= w_ext_a;
            r_b     <= w_ext_b;
            r_carry <= 1'b0;
            r_cnt   <= CNT_ZERO;
            r_res   <= '0;
        end else if (w_step) begin
            r_a     <= {1'b0, r_a[n:1]};
            r_b     <= {1'b0, r_b[n:1]};
            r_carry <= w_carry_nxt;
            r_cnt   <= r_cnt + CNT_ONE;
            r_res   <= {w_sum_bit, r_res[n-1:1]};
        end else begin
            r_a     <= r_a;
            r_b     <= r_b;
            r_carry <= r_carry;
            r_cnt   <= r_cnt;
            r_res   <= r_res;
        end
    end

    // Result outputs: only updated on completion, so no partial sum leaks out.
    // On the completing edge r_res already holds sum[n-1:0] and the adder is
    // producing sum[n]; the carry out of bit n is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_over <= 1'b0;
        end else if (w_finish) begin
            r_data <= r_res;
            r_over <= w_sum_bit;
        end else begin
            r_data <= r_data;
            r_over <= r_over;
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign data_o = r_data;
    assign over_o = r_over;

endmodule
